// File: rtl/results_conv_pkg.sv
// Shared definitions for the DTMF results converter: register addresses, keypad table, FSM state.
package results_conv_pkg;

  localparam int DATA_W = 16;

  localparam logic [3:0] ROW0      = 4'd0;
  localparam logic [3:0] ROW1      = 4'd1;
  localparam logic [3:0] ROW2      = 4'd2;
  localparam logic [3:0] ROW3      = 4'd3;
  localparam logic [3:0] COL0      = 4'd4;
  localparam logic [3:0] COL1      = 4'd5;
  localparam logic [3:0] COL2      = 4'd6;
  localparam logic [3:0] COL3      = 4'd7;
  localparam logic [3:0] FRAME_END = 4'd8;

  // 7-bit ASCII indexed by {row_idx, col_idx}
  localparam logic [6:0] KEYPAD [16] = '{
    7'h31, 7'h32, 7'h33, 7'h41,
    7'h34, 7'h35, 7'h36, 7'h42,
    7'h37, 7'h38, 7'h39, 7'h43,
    7'h2A, 7'h30, 7'h23, 7'h44
  };

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic logic [6:0] keypad_ascii(input logic [3:0] code);
    return KEYPAD[code];
  endfunction

endpackage

// File: rtl/results_conv_if.sv
// Result write bus plus decoded-digit outputs of the DTMF results converter.
interface results_conv_if;
  logic        rcc_clk;
  logic [3:0]  address;
  logic [15:0] din;
  logic        digit_clk;
  logic [7:0]  dout;
  logic        dout_flag;

  modport master (
    output rcc_clk, address, din,
    input  digit_clk, dout, dout_flag
  );

  modport slave (
    input  rcc_clk, address, din,
    output digit_clk, dout, dout_flag
  );
endinterface

// File: rtl/results_conv_max4.sv
// Combinational unsigned argmax of four values; ties resolve to the lowest index.
module results_conv_max4 #(
  parameter int DATA_W = 16
) (
  input  logic [3:0][DATA_W-1:0] vals,
  output logic [DATA_W-1:0]      max_val,
  output logic [1:0]             idx
);

  always_comb begin
    max_val = vals[0];
    idx     = 2'd0;
    // strict compare keeps the earlier index on equal magnitudes
    for (int i = 1; i < 4; i++) begin
      if (vals[i] > max_val) begin
        max_val = vals[i];
        idx     = 2'(i);
      end
    end
  end

endmodule

// File: rtl/results_conv.sv
// DTMF back end: latches row/column tone magnitudes, decodes the keypad digit on frame end, pulses digit_clk.
// Optional macro RESULTS_CONV_PARITY_EN puts even parity over dout[6:0] into dout[7].
module results_conv
  import results_conv_pkg::*;
#(
  parameter logic [15:0] THRESHOLD        = 16'h0100,
  parameter int          DIGIT_CLK_CYCLES = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         test_mode,
  results_conv_if.slave bus
);

  localparam int CNT_W = (DIGIT_CLK_CYCLES > 1) ? $clog2(DIGIT_CLK_CYCLES) : 1;

  logic                     rcc_d;
  logic                     wr;
  logic [3:0][DATA_W-1:0]   rows;
  logic [3:0][DATA_W-1:0]   cols;
  logic                     pend;
  logic                     busy;
  logic                     eval_p0;
  logic [DATA_W-1:0]        row_max;
  logic [DATA_W-1:0]        col_max;
  logic [1:0]               row_idx;
  logic [1:0]               col_idx;
  logic                     tone_vld;
  logic [3:0]               digit;
  state_t                   state_q;
  state_t                   state_d;
  logic [3:0]               last_q;
  logic [3:0]               last_d;
  logic                     report;
  logic                     flag;
  logic                     vld_p1;
  logic [7:0]               dout_p1;
  logic                     digit_clk_p2;
  logic [CNT_W-1:0]         cnt_p2;

  wire unused_test_mode = test_mode;

  function automatic logic [7:0] make_char(input logic [3:0] code);
    logic [6:0] a;
    a = keypad_ascii(code);
`ifdef RESULTS_CONV_PARITY_EN
    return {^a, a};
`else
    return {1'b0, a};
`endif
  endfunction

  assign wr = bus.rcc_clk & ~rcc_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      rcc_d <= 1'b0;
      rows  <= '0;
      cols  <= '0;
    end else begin
      rcc_d <= bus.rcc_clk;
      if (wr && !bus.address[3]) begin
        if (bus.address[2]) cols[bus.address[1:0]] <= bus.din;
        else                rows[bus.address[1:0]] <= bus.din;
      end
    end
  end

  // A frame end during an active report waits until the pulse is over; a newer one simply re-arms it.
  assign busy    = vld_p1 | digit_clk_p2;
  assign eval_p0 = pend & ~busy;

  always_ff @(posedge clk) begin
    if (reset)                                pend <= 1'b0;
    else if (wr && bus.address == FRAME_END)  pend <= 1'b1;
    else if (eval_p0)                         pend <= 1'b0;
  end

  // ---- stage p0: evaluate the latched magnitudes ----
  results_conv_max4 #(.DATA_W(DATA_W)) u_row_max (
    .vals    (rows),
    .max_val (row_max),
    .idx     (row_idx)
  );

  results_conv_max4 #(.DATA_W(DATA_W)) u_col_max (
    .vals    (cols),
    .max_val (col_max),
    .idx     (col_idx)
  );

  assign tone_vld = (row_max >= THRESHOLD) && (col_max >= THRESHOLD);
  assign digit    = {row_idx, col_idx};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    if (eval_p0) begin
      case (state_q)
        IDLE: begin
          if (tone_vld) begin
            state_d = HOLD;
            last_d  = digit;
          end
        end
        HOLD: begin
          if (!tone_vld)            state_d = IDLE;
          else if (digit != last_q) last_d  = digit;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    report = 1'b0;
    flag   = (state_q == HOLD);
    if (eval_p0 && tone_vld)
      report = (state_q == IDLE) || (digit != last_q);
  end

  // ---- stage p1: character load; stage p2: digit_clk pulse ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1       <= 1'b0;
      dout_p1      <= 8'h00;
      digit_clk_p2 <= 1'b0;
      cnt_p2       <= '0;
    end else begin
      vld_p1 <= report;
      if (report) dout_p1 <= make_char(digit);
      if (vld_p1) begin
        digit_clk_p2 <= 1'b1;
        cnt_p2       <= CNT_W'(DIGIT_CLK_CYCLES - 1);
      end else if (digit_clk_p2) begin
        if (cnt_p2 == '0) digit_clk_p2 <= 1'b0;
        else              cnt_p2       <= cnt_p2 - 1'b1;
      end
    end
  end

  assign bus.dout      = dout_p1;
  assign bus.digit_clk = digit_clk_p2;
  assign bus.dout_flag = flag;

endmodule

// File: tb/tb_results_conv.sv
// Directed and randomised checks of the DTMF results converter decode, reporting and pulse timing.
module tb_results_conv;

  logic clk = 1'b0;
  logic reset;
  logic test_mode;

  results_conv_if bus ();

  results_conv #(
    .THRESHOLD        (16'h0100),
    .DIGIT_CLK_CYCLES (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .test_mode (test_mode),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;
  int   width = 0;
  int   last_width = 0;
  logic dc_q = 1'b0;

  always @(negedge clk) begin
    if (bus.digit_clk) begin
      if (!dc_q) pulses++;
      width++;
    end else if (dc_q) begin
      last_width = width;
      width = 0;
    end
    dc_q = bus.digit_clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_char(input int r, input int c);
    string      keys;
    logic [7:0] ch;
    keys = "123A456B789C*0#D";
    ch = keys[r*4+c];
    ch[7] = 1'b0;
`ifdef RESULTS_CONV_PARITY_EN
    ch[7] = ^ch[6:0];
`endif
    return ch;
  endfunction

  function automatic int amax(input logic [3:0][15:0] v);
    int best;
    best = 0;
    for (int i = 1; i < 4; i++) if (v[i] > v[best]) best = i;
    return best;
  endfunction

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.address = a;
    bus.din     = d;
    bus.rcc_clk = 1'b1;
    @(negedge clk);
    bus.rcc_clk = 1'b0;
  endtask

  task automatic frame(input logic [7:0][15:0] v);
    for (int i = 0; i < 8; i++) wr(4'(i), v[i]);
    wr(4'd8, 16'h0);
  endtask

  task automatic settle();
    repeat (12) @(negedge clk);
    #1;
  endtask

  logic [7:0][15:0] f5, fz, fv;
  int   p0;
  logic m_hold;
  int   m_last;
  logic [7:0] m_dout;

  initial begin
    test_mode   = 1'b0;
    bus.rcc_clk = 1'b0;
    bus.address = 4'd0;
    bus.din     = 16'h0;
    reset       = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_dout", 32'(bus.dout), 32'h00);
    check("rst_dclk", 32'(bus.digit_clk), 32'h0);
    check("rst_flag", 32'(bus.dout_flag), 32'h0);
    reset = 1'b0;

    f5 = {8{16'h0010}};
    f5[1] = 16'h4000;
    f5[5] = 16'h5000;
    fz = '0;

    // digit '5' with exact latency
    p0 = pulses;
    frame(f5);
    @(negedge clk); #1;
    check("t2_dout_e1", 32'(bus.dout), 32'(exp_char(1, 1)));
    check("t2_dclk_e1", 32'(bus.digit_clk), 32'h0);
    @(negedge clk); #1;
    check("t2_dclk_e2", 32'(bus.digit_clk), 32'h1);
    settle();
    check("t2_pulses", 32'(pulses - p0), 32'd1);
    check("t2_width", 32'(last_width), 32'd4);
    check("t2_flag", 32'(bus.dout_flag), 32'h1);

    // repeat, quiet, repeat
    p0 = pulses;
    frame(f5); settle();
    check("t3_rep_pulses", 32'(pulses - p0), 32'd0);
    check("t3_rep_flag", 32'(bus.dout_flag), 32'h1);
    frame(fz); settle();
    check("t3_quiet_pulses", 32'(pulses - p0), 32'd0);
    check("t3_quiet_flag", 32'(bus.dout_flag), 32'h0);
    check("t3_quiet_dout", 32'(bus.dout), 32'(exp_char(1, 1)));
    frame(f5); settle();
    check("t3_again_pulses", 32'(pulses - p0), 32'd1);
    check("t3_again_dout", 32'(bus.dout), 32'(exp_char(1, 1)));

    // '*' then 'D'
    p0 = pulses;
    fv = {8{16'h0010}}; fv[3] = 16'h8000; fv[4] = 16'h8000;
    frame(fv); settle();
    check("t4_star_dout", 32'(bus.dout), 32'(exp_char(3, 0)));
    check("t4_star_pulses", 32'(pulses - p0), 32'd1);
    fv = {8{16'h0010}}; fv[3] = 16'h8000; fv[7] = 16'h8000;
    frame(fv); settle();
    check("t4_d_dout", 32'(bus.dout), 32'(exp_char(3, 3)));
    check("t4_d_pulses", 32'(pulses - p0), 32'd2);

    // tie to lowest row, then column just under threshold
    p0 = pulses;
    fv = {8{16'h0010}}; fv[0] = 16'h4000; fv[1] = 16'h4000; fv[4] = 16'h4000;
    frame(fv); settle();
    check("t5_tie_dout", 32'(bus.dout), 32'(exp_char(0, 0)));
    check("t5_tie_pulses", 32'(pulses - p0), 32'd1);
    fv[4] = 16'h00FF; fv[5] = 16'h00FF; fv[6] = 16'h00FF; fv[7] = 16'h00FF;
    frame(fv); settle();
    check("t5_thr_pulses", 32'(pulses - p0), 32'd1);
    check("t5_thr_flag", 32'(bus.dout_flag), 32'h0);
    check("t5_thr_dout", 32'(bus.dout), 32'(exp_char(0, 0)));

    // frame end arriving during a pulse is deferred, uses latest regs
    p0 = pulses;
    frame(f5);
    wr(4'd2, 16'h6000);
    wr(4'd8, 16'h0);
    settle();
    check("pend_pulses", 32'(pulses - p0), 32'd2);
    check("pend_dout", 32'(bus.dout), 32'(exp_char(2, 1)));
    check("pend_width", 32'(last_width), 32'd4);

    // reset in the middle of a pulse
    fv = {8{16'h0010}}; fv[0] = 16'h4000; fv[4] = 16'h4000;
    frame(fv);
    @(negedge clk);
    @(negedge clk); #1;
    check("mid_dclk_high", 32'(bus.digit_clk), 32'h1);
    reset = 1'b1;
    @(negedge clk); #1;
    check("mid_rst_dout", 32'(bus.dout), 32'h00);
    check("mid_rst_dclk", 32'(bus.digit_clk), 32'h0);
    check("mid_rst_flag", 32'(bus.dout_flag), 32'h0);
    reset = 1'b0;
    p0 = pulses;
    wr(4'd8, 16'h0); settle();
    check("mid_regs_clear", 32'(pulses - p0), 32'd0);

    // random frames against a reference model
    m_hold = 1'b0; m_last = -1; m_dout = 8'h00;
    for (int run = 0; run < 48; run++) begin
      for (int pass = 0; pass < 2; pass++) begin
        int rmax, cmax;
        logic vld, rep;
        logic [3:0][15:0] rv, cv;
        if (pass == 0) begin
          if ($urandom_range(0, 2) != 0)
            for (int i = 0; i < 8; i++) fv[i] = 16'($urandom_range(0, 1023));
          if ($urandom_range(0, 3) == 0)
            for (int i = 4; i < 8; i++) fv[i] = fv[i] & 16'h00FF;
        end else begin
          if ($urandom_range(0, 1) == 0) continue;
          fv = '0;
        end
        for (int i = 0; i < 4; i++) begin
          rv[i] = fv[i];
          cv[i] = fv[i+4];
        end
        rmax = amax(rv);
        cmax = amax(cv);
        vld = (rv[rmax] >= 16'h0100) && (cv[cmax] >= 16'h0100);
        rep = vld && (!m_hold || (m_last != rmax*4 + cmax));
        if (rep) m_dout = exp_char(rmax, cmax);
        m_hold = vld;
        if (vld) m_last = rmax*4 + cmax;
        p0 = pulses;
        frame(fv); settle();
        check("rnd_pulses", 32'(pulses - p0), rep ? 32'd1 : 32'd0);
        check("rnd_flag", 32'(bus.dout_flag), 32'(m_hold));
        check("rnd_dout", 32'(bus.dout), 32'(m_dout));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
